// File: rtl/fix2float.sv
// Signed fixed-point (FRAC_BITS fractional bits) to IEEE-754 float32 converter.
// Valid-only streaming pipeline: S1 sign/magnitude, S2 normalise, S3 round/pack, then output register.
module fix2float #(
  parameter int FRAC_BITS = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        src_valid,
  input  logic [31:0] src,
  output logic        dst_valid,
  output logic [31:0] dst
);

  // Stage 1: sign, magnitude, zero flag
  logic        s1_valid_q;
  logic        s1_sign_q;
  logic        s1_zero_q;
  logic [31:0] s1_mag_q;
  logic [31:0] s1_mag_d;

  // Two's-complement negate; 32'h80000000 maps onto 2^31 as an unsigned magnitude
  assign s1_mag_d = src[31] ? (~src + 32'd1) : src;

  always_ff @(posedge clk) begin
    if (!rstn) s1_valid_q <= 1'b0;
    else       s1_valid_q <= src_valid;
  end

  always_ff @(posedge clk) begin
    if (src_valid) begin
      s1_sign_q <= src[31];
      s1_zero_q <= (src == 32'd0);
      s1_mag_q  <= s1_mag_d;
    end
  end

  // Stage 2: leading-one position, normalise, biased exponent
  logic        s2_valid_q;
  logic        s2_sign_q;
  logic        s2_zero_q;
  logic [31:0] s2_norm_q;
  logic [8:0]  s2_exp_q;
  logic [4:0]  s2_pos_d;
  logic [31:0] s2_norm_d;
  logic [8:0]  s2_exp_d;

  always_comb begin
    s2_pos_d = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (s1_mag_q[i]) s2_pos_d = 5'(i);
    end
  end

  assign s2_norm_d = s1_mag_q << (5'd31 - s2_pos_d);
  assign s2_exp_d  = {4'd0, s2_pos_d} + 9'd127 - 9'(FRAC_BITS);

  always_ff @(posedge clk) begin
    if (!rstn) s2_valid_q <= 1'b0;
    else       s2_valid_q <= s1_valid_q;
  end

  always_ff @(posedge clk) begin
    if (s1_valid_q) begin
      s2_sign_q <= s1_sign_q;
      s2_zero_q <= s1_zero_q;
      s2_norm_q <= s2_norm_d;
      s2_exp_q  <= s2_exp_d;
    end
  end

  // Stage 3: round-to-nearest-even on the 23-bit mantissa, then pack
  logic        s3_valid_q;
  logic [31:0] s3_result_q;
  logic        s3_guard_d;
  logic        s3_sticky_d;
  logic        s3_inc_d;
  logic [23:0] s3_man_d;
  logic [8:0]  s3_exp_d;
  logic [31:0] s3_result_d;
  logic        unused_exp_msb;

  assign s3_guard_d  = s2_norm_q[7];
  assign s3_sticky_d = |s2_norm_q[6:0];
  assign s3_inc_d    = s3_guard_d & (s3_sticky_d | s2_norm_q[8]);
  assign s3_man_d    = {1'b0, s2_norm_q[30:8]} + {23'd0, s3_inc_d};
  // Mantissa carry-out leaves the low 23 bits zero, so only the exponent needs bumping
  assign s3_exp_d    = s3_man_d[23] ? (s2_exp_q + 9'd1) : s2_exp_q;
  assign s3_result_d = s2_zero_q ? 32'd0 : {s2_sign_q, s3_exp_d[7:0], s3_man_d[22:0]};
  assign unused_exp_msb = s3_exp_d[8];

  always_ff @(posedge clk) begin
    if (!rstn) s3_valid_q <= 1'b0;
    else       s3_valid_q <= s2_valid_q;
  end

  always_ff @(posedge clk) begin
    if (s2_valid_q) s3_result_q <= s3_result_d;
  end

  // Output register: loads only on a valid stage-3 result, otherwise holds
  logic        dst_valid_q;
  logic [31:0] dst_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      dst_valid_q <= 1'b0;
      dst_q       <= 32'd0;
    end else begin
      dst_valid_q <= s3_valid_q;
      if (s3_valid_q) dst_q <= s3_result_q;
    end
  end

  assign dst_valid = dst_valid_q;
  assign dst       = dst_q;

endmodule

// File: tb/tb_fix2float.sv
// Self-checking bench for fix2float (FRAC_BITS=16): directed vectors, random streaming,
// random bubbles, mid-stream reset and output hold, scored against a double-precision model.
module tb_fix2float;

  localparam int FRAC = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        src_valid;
  logic [31:0] src;
  logic        dst_valid;
  logic [31:0] dst;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic        vhist [3];
  logic [31:0] last_dst;

  fix2float #(.FRAC_BITS(FRAC)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .src_valid(src_valid),
    .src      (src),
    .dst_valid(dst_valid),
    .dst      (dst)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference: exact value in double precision, then rounded to single with round-half-even
  function automatic logic [31:0] ref_f(input logic [31:0] s);
    real         r;
    logic [63:0] b;
    logic [24:0] mr;
    logic [28:0] rem;
    logic        up;
    int          ef;
    if (s == 32'd0) return 32'd0;
    r   = real'($signed(s)) / (2.0 ** FRAC);
    b   = $realtobits(r);
    rem = b[28:0];
    up  = (rem > 29'h10000000) || ((rem == 29'h10000000) && b[29]);
    mr  = {2'b01, b[51:29]} + {24'd0, up};
    ef  = int'(b[62:52]) - 1023 + 127;
    if (mr[24]) begin
      ef = ef + 1;
      mr = 25'd0;
    end
    return {b[63], 8'(ef), mr[22:0]};
  endfunction

  function automatic logic [31:0] rnd_src();
    logic [31:0] r;
    r = 32'($urandom()) >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) r = ~r + 32'd1;
    return r;
  endfunction

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Driver: one clock cycle of stimulus followed by checks of the outputs
  task automatic step(input logic rst_n, input logic v, input logic [31:0] s, input logic [31:0] e);
    logic        exp_v;
    logic [31:0] want;
    @(negedge clk);
    rstn      = rst_n;
    src_valid = v;
    src       = v ? s : 32'($urandom());
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_q.delete();
      vhist    = '{1'b0, 1'b0, 1'b0};
      last_dst = 32'd0;
      check("rst_dst_valid", {31'd0, dst_valid}, 32'd0);
      check("rst_dst", dst, 32'd0);
    end else begin
      exp_v    = vhist[2];
      vhist[2] = vhist[1];
      vhist[1] = vhist[0];
      vhist[0] = v;
      check("valid_pattern", {31'd0, dst_valid}, {31'd0, exp_v});
      if (dst_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {31'd0, dst_valid}, 32'd0);
        end else begin
          want = exp_q.pop_front();
          check("dst", dst, want);
          last_dst = want;
        end
      end else begin
        check("hold", dst, last_dst);
      end
      if (v) exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [31:0] s);
    step(1'b1, 1'b1, s, ref_f(s));
  endtask

  task automatic send_known(input logic [31:0] s, input logic [31:0] e);
    step(1'b1, 1'b1, s, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic reset_cycle();
    step(1'b0, 1'b1, 32'($urandom()), 32'd0);
  endtask

  initial begin
    rstn      = 1'b0;
    src_valid = 1'b0;
    src       = 32'd0;
    last_dst  = 32'd0;
    vhist     = '{1'b0, 1'b0, 1'b0};

    reset_cycle();
    reset_cycle();

    // Basic conversions, each result three cycles after its sample
    send_known(32'h00010000, 32'h3F800000);
    idle(3);
    send_known(32'hFFFF0000, 32'hBF800000);
    idle(3);

    // Extremes and rounding, back to back
    send_known(32'h80000000, 32'hC7000000);
    send_known(32'h00000001, 32'h37800000);
    send_known(32'h00000000, 32'h00000000);
    send_known(32'h7FFFFFFF, 32'h47000000);
    send_known(32'h01000001, 32'h43800000);
    send_known(32'h01000003, 32'h43800002);
    idle(4);

    // Hold: result stays put while idle
    send_known(32'h00018000, 32'h3FC00000);
    idle(13);

    // Full-rate random stream
    for (int i = 0; i < 1000; i++) send(rnd_src());
    idle(4);

    // Random bubbles
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) send(rnd_src());
      else idle(1);
    end
    idle(4);

    // Reset with three samples in flight, then samples straight across the release
    send(rnd_src());
    send(rnd_src());
    send(rnd_src());
    reset_cycle();
    send_known(32'h00010000, 32'h3F800000);
    send_known(32'hFFFF0000, 32'hBF800000);
    send(rnd_src());
    idle(6);

    check("drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
